// File: rtl/touch_spi_xfer.sv
// touch_spi_xfer: SPI transfer engine for the touch-panel ADC.
// While ENA_TRANS is high it runs one X conversion, then one Y conversion.
// Each conversion is 24 DCLK periods: an 8-bit command is shifted out MSB
// first and a 12-bit result is shifted in. The results are committed to
// X_POS/Y_POS when the control FSM pulses FIN_TRANS.
module touch_spi_xfer #(
    parameter int unsigned CLK_DIV = 25,
    parameter logic [7:0]  CMD_X   = 8'hD0,
    parameter logic [7:0]  CMD_Y   = 8'h90
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        ENA_TRANS,
    input  logic        FIN_TRANS,
    input  logic        ADC_DOUT,
    output logic        ADC_DCLK,
    output logic        ADC_DIN,
    output logic        X_DONE,
    output logic        Y_DONE,
    output logic [11:0] X_POS,
    output logic [11:0] Y_POS,
    output logic        DATA_VALID
);

    localparam int unsigned      DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_X = 2'd1,
        CONV_Y = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [4:0]       idx_r, idx_s;
    logic             dclk_r, dclk_s;
    logic             din_r, din_s;
    logic [11:0]      sh_x_r, sh_x_s;
    logic [11:0]      sh_y_r, sh_y_s;
    logic             x_done_r, x_done_s;
    logic             y_done_r, y_done_s;
    logic [11:0]      x_pos_r, x_pos_s;
    logic [11:0]      y_pos_r, y_pos_s;
    logic             dv_r, dv_s;

    logic             tc_s;
    logic [4:0]       idx_inc_s;
    logic [7:0]       cur_cmd_s;
    logic             in_window_s;

    // Command bit for a given frame index: command MSB first, zeros after bit 7.
    function automatic logic cmd_bit(input logic [7:0] cmd, input logic [4:0] idx);
        logic b;
        if (idx < 5'd8) begin
            b = cmd[3'd7 - idx[2:0]];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    assign tc_s        = (div_r == DIV_TC);
    assign idx_inc_s   = idx_r + 5'd1;
    assign cur_cmd_s   = (state_r == CONV_Y) ? CMD_Y : CMD_X;
    assign in_window_s = (idx_r >= 5'd9) && (idx_r <= 5'd20);

    // Next-state and datapath update; DATA_VALID defaults low so it pulses.
    always_comb begin
        state_s  = state_r;
        div_s    = div_r;
        idx_s    = idx_r;
        dclk_s   = dclk_r;
        din_s    = din_r;
        sh_x_s   = sh_x_r;
        sh_y_s   = sh_y_r;
        x_done_s = x_done_r;
        y_done_s = y_done_r;
        x_pos_s  = x_pos_r;
        y_pos_s  = y_pos_r;
        dv_s     = 1'b0;
        case (state_r)
            IDLE: begin
                div_s  = '0;
                idx_s  = 5'd0;
                dclk_s = 1'b0;
                if (ENA_TRANS) begin
                    state_s = CONV_X;
                    din_s   = CMD_X[7];
                end else begin
                    din_s   = 1'b0;
                end
            end
            CONV_X, CONV_Y: begin
                if (!ENA_TRANS) begin
                    // Abort: drop the serial bus and forget any partial progress.
                    state_s  = IDLE;
                    div_s    = '0;
                    idx_s    = 5'd0;
                    dclk_s   = 1'b0;
                    din_s    = 1'b0;
                    x_done_s = 1'b0;
                    y_done_s = 1'b0;
                end else if (tc_s) begin
                    div_s = '0;
                    if (!dclk_r) begin
                        // DCLK rising: capture result bits D11..D0 at indices 9..20.
                        dclk_s = 1'b1;
                        if (in_window_s && (state_r == CONV_X)) begin
                            sh_x_s = {sh_x_r[10:0], ADC_DOUT};
                        end else if (in_window_s) begin
                            sh_y_s = {sh_y_r[10:0], ADC_DOUT};
                        end else begin
                            sh_x_s = sh_x_r;
                        end
                    end else begin
                        // DCLK falling: advance the frame, ADC_DIN changes only here.
                        dclk_s = 1'b0;
                        if (idx_r == 5'd23) begin
                            idx_s = 5'd0;
                            if (state_r == CONV_X) begin
                                state_s  = CONV_Y;
                                x_done_s = 1'b1;
                                din_s    = CMD_Y[7];
                            end else begin
                                state_s  = DONE;
                                y_done_s = 1'b1;
                                din_s    = 1'b0;
                            end
                        end else begin
                            idx_s = idx_inc_s;
                            din_s = cmd_bit(cur_cmd_s, idx_inc_s);
                        end
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            DONE: begin
                dclk_s = 1'b0;
                din_s  = 1'b0;
                if (FIN_TRANS) begin
                    // Commit wins even if ENA_TRANS drops in the same cycle.
                    state_s  = IDLE;
                    x_pos_s  = sh_x_r;
                    y_pos_s  = sh_y_r;
                    dv_s     = 1'b1;
                    x_done_s = 1'b0;
                    y_done_s = 1'b0;
                end else if (!ENA_TRANS) begin
                    state_s  = IDLE;
                    x_done_s = 1'b0;
                    y_done_s = 1'b0;
                end else begin
                    x_done_s = 1'b1;
                    y_done_s = 1'b1;
                end
            end
            default: begin
                state_s  = IDLE;
                div_s    = '0;
                idx_s    = 5'd0;
                dclk_s   = 1'b0;
                din_s    = 1'b0;
                x_done_s = 1'b0;
                y_done_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r  <= IDLE;
            div_r    <= '0;
            idx_r    <= 5'd0;
            dclk_r   <= 1'b0;
            din_r    <= 1'b0;
            sh_x_r   <= 12'd0;
            sh_y_r   <= 12'd0;
            x_done_r <= 1'b0;
            y_done_r <= 1'b0;
            x_pos_r  <= 12'd0;
            y_pos_r  <= 12'd0;
            dv_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            idx_r    <= idx_s;
            dclk_r   <= dclk_s;
            din_r    <= din_s;
            sh_x_r   <= sh_x_s;
            sh_y_r   <= sh_y_s;
            x_done_r <= x_done_s;
            y_done_r <= y_done_s;
            x_pos_r  <= x_pos_s;
            y_pos_r  <= y_pos_s;
            dv_r     <= dv_s;
        end
    end

    assign ADC_DCLK   = dclk_r;
    assign ADC_DIN    = din_r;
    assign X_DONE     = x_done_r;
    assign Y_DONE     = y_done_r;
    assign X_POS      = x_pos_r;
    assign Y_POS      = y_pos_r;
    assign DATA_VALID = dv_r;

endmodule

// File: tb/tb_touch_spi_xfer.sv
// Testbench for touch_spi_xfer: two instances (CLK_DIV=25 and CLK_DIV=1)
// driven by a behavioural ADC model, checked against frame-level rules.
module tb_touch_spi_xfer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena      [2];
    logic        fin      [2];
    logic        adc_dout [2];
    wire  [1:0]  dclk, din, xd, yd, dv;
    wire  [11:0] xpos0, ypos0, xpos1, ypos1;

    int          n_vec = 0;
    int          n_err = 0;

    logic [11:0] adc_x [2];
    logic [11:0] adc_y [2];
    int          rise_cnt  [2];
    logic        prev_dclk [2];
    logic [47:0] din_log   [2];
    logic [11:0] last_x [2];
    logic [11:0] last_y [2];

    always #5 clk = ~clk;

    touch_spi_xfer #(.CLK_DIV(25)) dut0 (
        .CLK(clk), .RST_n(rst_n), .ENA_TRANS(ena[0]), .FIN_TRANS(fin[0]),
        .ADC_DOUT(adc_dout[0]), .ADC_DCLK(dclk[0]), .ADC_DIN(din[0]),
        .X_DONE(xd[0]), .Y_DONE(yd[0]), .X_POS(xpos0), .Y_POS(ypos0),
        .DATA_VALID(dv[0])
    );

    touch_spi_xfer #(.CLK_DIV(1)) dut1 (
        .CLK(clk), .RST_n(rst_n), .ENA_TRANS(ena[1]), .FIN_TRANS(fin[1]),
        .ADC_DOUT(adc_dout[1]), .ADC_DCLK(dclk[1]), .ADC_DIN(din[1]),
        .X_DONE(xd[1]), .Y_DONE(yd[1]), .X_POS(xpos1), .Y_POS(ypos1),
        .DATA_VALID(dv[1])
    );

    function automatic logic [11:0] xpos_of(input int s);
        return (s == 0) ? xpos0 : xpos1;
    endfunction

    function automatic logic [11:0] ypos_of(input int s);
        return (s == 0) ? ypos0 : ypos1;
    endfunction

    // ADC output for the n-th DCLK rise of a transfer (24 rises per conversion).
    function automatic logic adc_bit(input int s, input int n);
        int          idx;
        logic [11:0] w;
        if (n >= 48) return 1'b0;
        idx = n % 24;
        w   = (n < 24) ? adc_x[s] : adc_y[s];
        if (idx >= 9 && idx <= 20) return w[20 - idx];
        return 1'b0;
    endfunction

    // ADC model: counts DCLK rises, logs ADC_DIN at each rise, updates DOUT after falls.
    always @(posedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (!ena[s] || !rst_n) begin
                rise_cnt[s] = 0;
                adc_dout[s] = 1'b0;
            end else if (dclk[s] && !prev_dclk[s]) begin
                if (rise_cnt[s] < 48) din_log[s][rise_cnt[s]] = din[s];
                rise_cnt[s] = rise_cnt[s] + 1;
            end else if (!dclk[s] && prev_dclk[s]) begin
                adc_dout[s] = adc_bit(s, rise_cnt[s]);
            end
            prev_dclk[s] = dclk[s];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One transfer. mode 0: FIN; 1: FIN with ENA drop; 2: ENA drop only; 3: abort at abort_at.
    task automatic do_xfer(input int s, input logic [11:0] x, input logic [11:0] y,
                           input int mode, input int abort_at,
                           input logic [11:0] exp_x, input logic [11:0] exp_y,
                           input logic exp_dv);
        int          d, t, tx, ty;
        bit          stop, dv_seen;
        logic [47:0] din_exp;
        logic [7:0]  cmd;
        d = (s == 0) ? 25 : 1;
        adc_x[s] = x;
        adc_y[s] = y;
        @(negedge clk);
        ena[s] = 1'b1;
        @(posedge clk);
        t = 0; tx = -1; ty = -1; stop = 1'b0; dv_seen = 1'b0;
        while (!stop) begin
            @(negedge clk);
            if (dv[s]) dv_seen = 1'b1;
            if (xd[s] && tx < 0) tx = t;
            if (yd[s]) begin
                ty = t;
                stop = 1'b1;
            end else if (mode == 3 && t == abort_at) begin
                stop = 1'b1;
            end else if (t > 100 * d + 50) begin
                stop = 1'b1;
            end else begin
                @(posedge clk);
                t++;
            end
        end
        check("no_dv_during_conv", 64'(dv_seen), 64'd0);
        if (mode == 3) begin
            ena[s] = 1'b0;
            @(negedge clk);
            check("abort_bus_idle", {62'd0, dclk[s], din[s]}, 64'd0);
            check("abort_flags", {62'd0, xd[s], yd[s]}, 64'd0);
            dv_seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (dv[s] || dclk[s]) dv_seen = 1'b1;
            end
            check("abort_quiet", 64'(dv_seen), 64'd0);
            check("abort_pos", {xpos_of(s), ypos_of(s)}, {exp_x, exp_y});
            return;
        end
        check("x_done_time", 64'(tx), 64'(48 * d));
        check("y_done_time", 64'(ty), 64'(96 * d));
        if (ty < 0) begin
            ena[s] = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        check("dclk_rises", 64'(rise_cnt[s]), 64'd48);
        for (int n = 0; n < 48; n++) begin
            cmd = (n < 24) ? 8'hD0 : 8'h90;
            din_exp[n] = ((n % 24) < 8) ? cmd[7 - (n % 24)] : 1'b0;
        end
        check("din_at_rises", 64'(din_log[s]), 64'(din_exp));
        @(posedge clk);
        @(negedge clk);
        check("done_flags_held", {61'd0, xd[s], yd[s], dv[s]}, 64'd6);
        if (mode == 2) begin
            ena[s] = 1'b0;
        end else begin
            fin[s] = 1'b1;
            if (mode == 1) ena[s] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        fin[s] = 1'b0;
        ena[s] = 1'b0;
        check("exit_dv", 64'(dv[s]), 64'(exp_dv));
        check("exit_flags", {62'd0, xd[s], yd[s]}, 64'd0);
        check("exit_pos", {xpos_of(s), ypos_of(s)}, {exp_x, exp_y});
        @(negedge clk);
        check("dv_one_cycle", 64'(dv[s]), 64'd0);
    endtask

    typedef struct {
        int          sel;
        logic [11:0] x;
        logic [11:0] y;
        int          mode;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        edv;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          t;
        bit          seen;
        logic [11:0] rx, ry, ex, ey;
        int          mode, ab;

        tbl[0] = '{0, 12'hA5C, 12'h3F1, 0, 12'hA5C, 12'h3F1, 1'b1};
        tbl[1] = '{1, 12'hFFF, 12'h001, 0, 12'hFFF, 12'h001, 1'b1};
        tbl[2] = '{0, 12'h123, 12'h456, 1, 12'h123, 12'h456, 1'b1};
        tbl[3] = '{0, 12'h777, 12'h888, 2, 12'h123, 12'h456, 1'b0};
        tbl[4] = '{1, 12'h5A5, 12'hA5A, 2, 12'hFFF, 12'h001, 1'b0};
        tbl[5] = '{1, 12'h000, 12'h800, 1, 12'h000, 12'h800, 1'b1};

        for (int s = 0; s < 2; s++) begin
            ena[s] = 1'b0; fin[s] = 1'b0; adc_dout[s] = 1'b0;
            adc_x[s] = 12'd0; adc_y[s] = 12'd0;
            rise_cnt[s] = 0; prev_dclk[s] = 1'b0; din_log[s] = 48'd0;
            last_x[s] = 12'd0; last_y[s] = 12'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs0", {dclk[0], din[0], xd[0], yd[0], dv[0], xpos0, ypos0}, 64'd0);
        check("reset_outs1", {dclk[1], din[1], xd[1], yd[1], dv[1], xpos1, ypos1}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table of full transfers with fixed expectations.
        for (int i = 0; i < 6; i++) begin
            do_xfer(tbl[i].sel, tbl[i].x, tbl[i].y, tbl[i].mode, 0,
                    tbl[i].ex, tbl[i].ey, tbl[i].edv);
            last_x[tbl[i].sel] = tbl[i].ex;
            last_y[tbl[i].sel] = tbl[i].ey;
            repeat (2) @(negedge clk);
        end

        // Abort during DCLK index 14 of CONV_X, then a fresh transfer.
        adc_x[0] = 12'hBAD; adc_y[0] = 12'hBAD;
        ena[0] = 1'b1;
        t = 0;
        while (!(rise_cnt[0] == 15 && dclk[0]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abort_reach_idx14", 64'(t < 2000), 64'd1);
        ena[0] = 1'b0;
        @(negedge clk);
        check("abort14_dclk_low", {62'd0, dclk[0], din[0]}, 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dv[0] || dclk[0]) seen = 1'b1;
        end
        check("abort14_quiet", 64'(seen), 64'd0);
        check("abort14_pos", {xpos0, ypos0}, {last_x[0], last_y[0]});
        do_xfer(0, 12'hC3A, 12'h5E7, 0, 0, 12'hC3A, 12'h5E7, 1'b1);
        last_x[0] = 12'hC3A; last_y[0] = 12'h5E7;
        repeat (2) @(negedge clk);

        // Randomized transfers on the fast instance against the reference model.
        for (int i = 0; i < 24; i++) begin
            rx   = 12'($urandom);
            ry   = 12'($urandom);
            mode = int'($urandom_range(0, 3));
            ab   = int'($urandom_range(1, 94));
            ex   = (mode < 2) ? rx : last_x[1];
            ey   = (mode < 2) ? ry : last_y[1];
            do_xfer(1, rx, ry, mode, ab, ex, ey, (mode < 2));
            last_x[1] = ex; last_y[1] = ey;
            repeat (2) @(negedge clk);
        end

        // Asynchronous reset in the middle of CONV_Y.
        ena[0] = 1'b1;
        repeat (1500) @(negedge clk);
        check("in_conv_y", {62'd0, xd[0], yd[0]}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {dclk[0], din[0], xd[0], yd[0], dv[0], xpos0, ypos0}, 64'd0);
        ena[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (dclk[0] || din[0] || xd[0] || dv[0]) seen = 1'b1;
        end
        check("idle_after_reset", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule
